// File: rtl/chase_engine.sv
// chase_engine: multi-thread pointer-chasing load engine for one MC read port.
// Seeds one chain per thread from a table of 8-byte pointers, then follows
// each returned pointer (plus a field offset) until the shared load budget is
// spent or, optionally, a chain returns a null pointer.
module chase_engine #(
  parameter int unsigned ADR_W        = 48,
  parameter int unsigned TAG_W        = 32,
  parameter int unsigned THR_W        = 9,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             idle,
  output logic             done,
  input  logic [31:0]      edge_count,
  input  logic [THR_W-1:0] num_threads,
  input  logic [ADR_W-1:0] base_address,
  input  logic [ADR_W-1:0] next_offset,
  input  logic             null_stop,
  output logic             mc_req_ld,
  output logic [ADR_W-1:0] mc_req_vadr,
  output logic [TAG_W-1:0] mc_req_rdctl,
  input  logic             mc_rd_rq_stall,
  input  logic             mc_rsp_push,
  input  logic [TAG_W-1:0] mc_rsp_rdctl,
  input  logic [63:0]      mc_rsp_data,
  output logic             mc_rsp_stall,
  output logic [31:0]      ld_issued
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = TAG_W + ADR_W;

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               r_rst;
  logic               r_stall;
  logic               r_rsp_push;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [63:0]        r_rsp_data;
  logic [ADR_W-1:0]   r_base, r_off;
  logic               r_null_stop;
  logic [THR_W-1:0]   r_seed_cnt, r_seed_idx;
  logic [31:0]        r_budget, r_outst, r_ld_issued;
  logic               r_req_ld, r_done;
  logic [ADR_W-1:0]   r_req_vadr;
  logic [TAG_W-1:0]   r_req_rdctl;
  logic [FW-1:0]      r_mem [DEPTH];
  logic [PW-1:0]      r_wp, r_rp;
  logic [PW:0]        r_cnt;

  logic [THR_W-1:0]   w_seed_cnt;
  logic               w_start, w_rsp, w_push, w_fifo_empty;
  logic               w_seed_issue, w_run_issue, w_issue, w_seed_last;
  logic [FW-1:0]      w_head;

  assign w_seed_cnt   = (edge_count < 32'(num_threads)) ? edge_count[THR_W-1:0] : num_threads;
  assign w_start      = (r_state == S_IDLE) && start;
  assign w_rsp        = r_rsp_push && ((r_state == S_SEED) || (r_state == S_RUN));
  assign w_push       = w_rsp && (r_budget != '0) && !(r_null_stop && (r_rsp_data == '0));
  assign w_fifo_empty = (r_cnt == '0);
  assign w_seed_issue = (r_state == S_SEED) && !r_stall;
  assign w_run_issue  = (r_state == S_RUN) && !w_fifo_empty && !r_stall;
  assign w_issue      = w_seed_issue || w_run_issue;
  assign w_seed_last  = (r_seed_idx == (r_seed_cnt - THR_W'(1)));
  assign w_head       = r_mem[r_rp];

  assign idle         = ~start && (r_state == S_IDLE);
  assign done         = r_done;
  assign mc_req_ld    = r_req_ld;
  assign mc_req_vadr  = r_req_vadr;
  assign mc_req_rdctl = r_req_rdctl;
  assign ld_issued    = r_ld_issued;
  assign mc_rsp_stall = (r_state == S_SEED) || (r_cnt > (PW+1)'(DEPTH - AFULL_MARGIN));

  // Reset is retimed once before it reaches any other state.
  always_ff @(posedge clk) begin
    r_rst <= reset;
  end

  // Register MC stall and response inputs.
  always_ff @(posedge clk) begin
    if (r_rst) begin
      r_stall    <= 1'b0;
      r_rsp_push <= 1'b0;
      r_rsp_tag  <= '0;
      r_rsp_data <= '0;
    end else begin
      r_stall    <= mc_rd_rq_stall;
      r_rsp_push <= mc_rsp_push;
      r_rsp_tag  <= mc_rsp_rdctl;
      r_rsp_data <= mc_rsp_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (r_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = (w_seed_cnt == '0) ? S_DONE : S_SEED;
      S_SEED: if (w_seed_issue && w_seed_last) w_next = S_RUN;
      S_RUN:  if ((r_outst == '0) && w_fifo_empty) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Config latch, request register, budget and load counters.
  always_ff @(posedge clk) begin
    if (r_rst) begin
      r_base      <= '0;
      r_off       <= '0;
      r_null_stop <= 1'b0;
      r_seed_cnt  <= '0;
      r_seed_idx  <= '0;
      r_budget    <= '0;
      r_outst     <= '0;
      r_ld_issued <= '0;
      r_req_ld    <= 1'b0;
      r_req_vadr  <= '0;
      r_req_rdctl <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done   <= (r_state == S_DONE);
      r_req_ld <= w_issue;
      if (w_seed_issue) begin
        r_req_vadr  <= r_base + (ADR_W'(r_seed_idx) << 3);
        r_req_rdctl <= TAG_W'(r_seed_idx);
      end else if (w_run_issue) begin
        r_req_vadr  <= w_head[ADR_W-1:0];
        r_req_rdctl <= w_head[FW-1:ADR_W];
      end
      if (w_start) begin
        r_base      <= base_address;
        r_off       <= next_offset;
        r_null_stop <= null_stop;
        r_seed_cnt  <= w_seed_cnt;
        r_seed_idx  <= '0;
        r_budget    <= edge_count - 32'(w_seed_cnt);
        r_outst     <= '0;
        r_ld_issued <= '0;
      end else begin
        if (w_seed_issue) r_seed_idx <= r_seed_idx + THR_W'(1);
        if (w_push)       r_budget   <= r_budget - 32'd1;
        if (w_issue)      r_ld_issued <= r_ld_issued + 32'd1;
        case ({w_issue, w_rsp})
          2'b10:   r_outst <= r_outst + 32'd1;
          2'b01:   r_outst <= r_outst - 32'd1;
          default: r_outst <= r_outst;
        endcase
      end
    end
  end

  // Chase FIFO storage: {tag, next address}.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {r_rsp_tag, r_rsp_data[ADR_W-1:0] + r_off};
  end

  // Chase FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (r_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)      r_wp <= r_wp + PW'(1);
      if (w_run_issue) r_rp <= r_rp + PW'(1);
      case ({w_push, w_run_issue})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
